spi_master: RTL and testbench

- Hardware SPI master; supersedes the bit-banged SCLK/MOSI/MISO and SD-select glue in the CPLD.
- Four-register window in the $FE30 I/O block; bus-side address decode lives in the top-level glue.
- Adds full-byte shifting, a programmable clock divider, all four CPOL/CPHA modes, MSB/LSB-first order, a parametrised number of chip selects, done/overrun status and an optional interrupt.

---
 rtl/spi_master_pkg.sv | 24 ++
 rtl/spi_clkdiv.sv | 27 ++
 rtl/spi_master.sv | 152 +++++++++++++++
 tb/tb_spi_master.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_master_pkg.sv
// Register map, control/status bit positions and controller states shared by the SPI master.
package spi_master_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_CTRL = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_SEL  = 2'd3;

  localparam int CTRL_CPOL  = 0;
  localparam int CTRL_CPHA  = 1;
  localparam int CTRL_IRQEN = 2;
  localparam int CTRL_LSBF  = 3;

  localparam int STAT_OVR  = 5;
  localparam int STAT_DONE = 6;
  localparam int STAT_BUSY = 7;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } spiState_e;

endpackage

// File: rtl/spi_clkdiv.sv
// Half-period timer for SCLK: one-cycle tick every divVal+1 cycles while running.
module spi_clkdiv #(
  parameter int DIVW = 8
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            restart,
  input  logic            run,
  input  logic [DIVW-1:0] divVal,
  output logic            tick
);

  logic [DIVW-1:0] countReg;

  assign tick = run && (countReg == '0);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      countReg <= '0;
    end else if (restart) begin
      countReg <= divVal;
    end else if (run) begin
      countReg <= (countReg == '0) ? divVal : countReg - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// Byte-wide SPI master with four-register bus window, programmable SCLK divider,
// all CPOL/CPHA modes, bit-order select, chip selects and done/overrun status.
module spi_master
  import spi_master_pkg::*;
#(
  parameter int NCS     = 2,
  parameter int DIVW    = 8,
  parameter int RST_DIV = 23
) (
  input  logic           MHZ48,
  input  logic           nRES,
  input  logic           WE,
  input  logic           RE,
  input  logic [1:0]     ADDR,
  input  logic [7:0]     DIN,
  output logic [7:0]     DOUT,
  output logic           SCLK,
  output logic           MOSI,
  input  logic           MISO,
  output logic [NCS-1:0] nSS,
  output logic           nIRQ
);

  spiState_e       stateReg, stateNext;
  logic [3:0]      ctrlReg;
  logic [DIVW-1:0] divReg;
  logic [NCS-1:0]  selReg;
  logic [7:0]      rxReg, rxShift, txShift, status;
  logic [4:0]      toggleCnt;
  logic            busyReg, doneReg, ovrReg, sclkReg, mosiReg;
  logic            tick, startXfer, lsbf, cpha, leading, lastToggle, sampleEdge, driveEdge;

  assign lsbf       = ctrlReg[CTRL_LSBF];
  assign cpha       = ctrlReg[CTRL_CPHA];
  assign startXfer  = WE && (ADDR == REG_DATA) && !busyReg;
  // Even toggle count before the edge means SCLK is still at CPOL, so this edge leaves it.
  assign leading    = ~toggleCnt[0];
  assign lastToggle = (toggleCnt == 5'd15);
  assign sampleEdge = leading ^ cpha;
  assign driveEdge  = cpha ? leading : (!leading && !lastToggle);

  spi_clkdiv #(.DIVW(DIVW)) clkDiv (
    .clk     (MHZ48),
    .rstN    (nRES),
    .restart (startXfer),
    .run     (stateReg == SHIFT),
    .divVal  (divReg),
    .tick    (tick)
  );

  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (startXfer) stateNext = SHIFT;
      SHIFT:   if (tick && lastToggle) stateNext = FINISH;
      FINISH:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge MHZ48 or negedge nRES) begin
    if (!nRES) begin
      ctrlReg   <= '0;
      divReg    <= DIVW'(RST_DIV);
      selReg    <= '0;
      rxReg     <= '0;
      rxShift   <= '0;
      txShift   <= '0;
      toggleCnt <= '0;
      busyReg   <= 1'b0;
      doneReg   <= 1'b0;
      ovrReg    <= 1'b0;
      sclkReg   <= 1'b0;
      mosiReg   <= 1'b1;
    end else begin
      // Read-clears come first so that a coinciding set below takes priority.
      if (RE && ADDR == REG_DATA) doneReg <= 1'b0;
      if (RE && ADDR == REG_CTRL) ovrReg <= 1'b0;
      if (WE && busyReg) ovrReg <= 1'b1;

      if (WE && !busyReg) begin
        case (ADDR)
          REG_DATA: begin
            busyReg   <= 1'b1;
            doneReg   <= 1'b0;
            toggleCnt <= '0;
            rxShift   <= '0;
            if (!cpha) begin
              mosiReg <= lsbf ? DIN[0] : DIN[7];
              txShift <= lsbf ? (DIN >> 1) : (DIN << 1);
            end else begin
              txShift <= DIN;
            end
          end
          REG_CTRL: begin
            ctrlReg <= DIN[3:0];
            sclkReg <= DIN[CTRL_CPOL];
          end
          REG_DIV: divReg <= DIVW'(DIN);
          default: selReg <= NCS'(DIN);
        endcase
      end

      if (stateReg == SHIFT && tick) begin
        sclkReg   <= ~sclkReg;
        toggleCnt <= toggleCnt + 5'd1;
        if (sampleEdge) begin
          rxShift <= lsbf ? {MISO, rxShift[7:1]} : {rxShift[6:0], MISO};
        end
        if (driveEdge) begin
          mosiReg <= lsbf ? txShift[0] : txShift[7];
          txShift <= lsbf ? (txShift >> 1) : (txShift << 1);
        end
      end

      if (stateReg == FINISH) begin
        rxReg   <= rxShift;
        doneReg <= 1'b1;
        busyReg <= 1'b0;
      end
    end
  end

  always_comb begin
    status            = 8'h00;
    status[STAT_BUSY] = busyReg;
    status[STAT_DONE] = doneReg;
    status[STAT_OVR]  = ovrReg;
    status[3:0]       = ctrlReg;
    DOUT              = 8'h00;
    case (ADDR)
      REG_DATA: DOUT = rxReg;
      REG_CTRL: DOUT = status;
      REG_DIV:  DOUT = 8'(divReg);
      default:  DOUT = 8'(selReg);
    endcase
  end

  assign SCLK = sclkReg;
  assign MOSI = mosiReg;
  assign nSS  = ~selReg;
  assign nIRQ = ~(doneReg & ctrlReg[CTRL_IRQEN]);

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: a slave model on the SPI pins plus a byte-level
// reference for MOSI order, RX assembly, completion timing and status bits.
module tb_spi_master;
  import spi_master_pkg::*;

  localparam int NCS = 2;

  logic           MHZ48 = 1'b0;
  logic           nRES  = 1'b0;
  logic           WE    = 1'b0;
  logic           RE    = 1'b0;
  logic [1:0]     ADDR  = 2'd0;
  logic [7:0]     DIN   = 8'h00;
  logic [7:0]     DOUT;
  logic           SCLK, MOSI, MISO, nIRQ;
  logic [NCS-1:0] nSS;

  logic       loopOn    = 1'b0;
  logic       misoSlave = 1'b1;
  logic       monOn     = 1'b0;
  logic       curCpha   = 1'b0;
  logic       sclkPrev  = 1'b0;
  logic [7:0] slvByte   = 8'h00;
  int         edgeCnt   = 0;
  int         cyc       = 0;
  logic       mosiQ[$];
  int         riseQ[$];
  int         checkCount = 0;
  int         errorCount = 0;

  assign MISO = loopOn ? MOSI : misoSlave;

  spi_master #(.NCS(NCS), .DIVW(8), .RST_DIV(23)) dut (
    .MHZ48 (MHZ48),
    .nRES  (nRES),
    .WE    (WE),
    .RE    (RE),
    .ADDR  (ADDR),
    .DIN   (DIN),
    .DOUT  (DOUT),
    .SCLK  (SCLK),
    .MOSI  (MOSI),
    .MISO  (MISO),
    .nSS   (nSS),
    .nIRQ  (nIRQ)
  );

  always #5 MHZ48 = ~MHZ48;
  always @(posedge MHZ48) cyc <= cyc + 1;

  // Slave model: watches SCLK between clock edges, samples MOSI and presents MSB-first data.
  always @(negedge MHZ48) begin
    if (monOn && SCLK !== sclkPrev) begin
      edgeCnt++;
      if (SCLK) riseQ.push_back(cyc);
      if ((edgeCnt % 2 == 1) != curCpha) mosiQ.push_back(MOSI);
      if (!curCpha && edgeCnt % 2 == 0 && edgeCnt / 2 < 8) misoSlave = slvByte[7 - edgeCnt / 2];
      if (curCpha && edgeCnt % 2 == 1) misoSlave = slvByte[7 - (edgeCnt - 1) / 2];
    end
    sclkPrev = SCLK;
  end

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bitRev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    @(negedge MHZ48);
    WE = 1'b1; ADDR = a; DIN = d;
    @(negedge MHZ48);
    WE = 1'b0;
  endtask

  task automatic readReg(input logic [1:0] a, output logic [7:0] d);
    @(negedge MHZ48);
    RE = 1'b1; ADDR = a;
    #1 d = DOUT;
    @(negedge MHZ48);
    RE = 1'b0;
  endtask

  task automatic runXfer(input logic cpol, input logic cpha, input logic lsbf, input logic irqen,
                         input logic loop, input int dv, input logic [7:0] tx, input logic [7:0] slv,
                         input logic ovrTest, input logic collide);
    logic [7:0] ctrl, rd, seq, expRx;
    int         n, doneAt;
    logic       seen;
    int         nDone = 16 * (dv + 1) + 2;
    ctrl = {4'h0, lsbf, irqen, cpha, cpol};
    expRx = loop ? tx : (lsbf ? bitRev(slv) : slv);
    writeReg(REG_CTRL, ctrl);
    writeReg(REG_DIV, 8'(dv));
    checkVal("sclkIdle", SCLK, cpol);
    curCpha = cpha; slvByte = slv; loopOn = loop; misoSlave = slv[7];
    edgeCnt = 0; mosiQ.delete(); riseQ.delete(); monOn = 1'b1;
    @(negedge MHZ48);
    WE = 1'b1; ADDR = REG_DATA; DIN = tx;
    seen = 1'b0; doneAt = -1;
    for (n = 1; n <= nDone + 40 && !seen; n++) begin
      @(negedge MHZ48);
      WE = 1'b0; RE = 1'b0; ADDR = REG_CTRL;
      if (n == nDone - 1) checkVal("irqPre", nIRQ, 1'b1);
      if (ovrTest && n == 4) begin
        WE = 1'b1; ADDR = REG_DATA; DIN = 8'hFF;
      end else if (ovrTest && n == 5) begin
        WE = 1'b1; ADDR = REG_SEL; DIN = 8'h02;
      end else if (collide && n == nDone - 1) begin
        RE = 1'b1; ADDR = REG_DATA;
      end else begin
        #1;
        if (DOUT[STAT_BUSY] == 1'b0) begin
          seen = 1'b1; doneAt = n;
        end
      end
    end
    WE = 1'b0; RE = 1'b0;
    monOn = 1'b0;
    checkVal("doneCycle", doneAt, nDone);
    checkVal("irqDone", nIRQ, !irqen);
    checkVal("sclkEnd", SCLK, cpol);
    checkVal("rises", riseQ.size(), 8);
    for (int i = 1; i < riseQ.size(); i++) checkVal("riseGap", riseQ[i] - riseQ[i-1], 2 * (dv + 1));
    checkVal("mosiBits", mosiQ.size(), 8);
    seq = 8'h00;
    for (int i = 0; i < 8 && i < mosiQ.size(); i++) seq[7 - i] = mosiQ[i];
    checkVal("mosiSeq", seq, lsbf ? bitRev(tx) : tx);
    readReg(REG_CTRL, rd);
    checkVal("statusA", rd, {2'b01, ovrTest, 1'b0, ctrl[3:0]});
    readReg(REG_CTRL, rd);
    checkVal("statusB", rd, {4'b0100, ctrl[3:0]});
    readReg(REG_SEL, rd);
    checkVal("selKept", rd, 8'h01);
    checkVal("nss", nSS, 2'b10);
    readReg(REG_DATA, rd);
    checkVal("rxData", rd, expRx);
    readReg(REG_CTRL, rd);
    checkVal("doneClr", rd, {4'b0000, ctrl[3:0]});
    checkVal("irqClr", nIRQ, 1'b1);
    $display("xfer cpol=%0d cpha=%0d lsbf=%0d div=%0d tx=%02h rx=%02h done@%0d", cpol, cpha, lsbf, dv, tx, expRx, doneAt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    repeat (3) @(negedge MHZ48);
    nRES = 1'b1;
    checkVal("rstSclk", SCLK, 1'b0);
    checkVal("rstMosi", MOSI, 1'b1);
    checkVal("rstNss", nSS, 2'b11);
    checkVal("rstIrq", nIRQ, 1'b1);
    readReg(REG_CTRL, rd); checkVal("rstStatus", rd, 8'h00);
    readReg(REG_DIV, rd);  checkVal("rstDiv", rd, 8'd23);
    readReg(REG_SEL, rd);  checkVal("rstSel", rd, 8'h00);
    readReg(REG_DATA, rd); checkVal("rstRx", rd, 8'h00);

    writeReg(REG_SEL, 8'h01);
    checkVal("selNss", nSS, 2'b10);

    runXfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 8'h00, 1'b0, 1'b0);
    runXfer(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 8'h81, 8'h3C, 1'b0, 1'b0);
    runXfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 7, 8'hC6, 8'h00, 1'b1, 1'b0);
    runXfer(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 8'h5A, 8'h96, 1'b0, 1'b1);

    for (int k = 0; k < 16; k++) begin
      runXfer(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    writeReg(REG_CTRL, 8'h00);
    writeReg(REG_DIV, 8'd3);
    curCpha = 1'b0; slvByte = 8'hFF; misoSlave = 1'b1; loopOn = 1'b0;
    edgeCnt = 0; mosiQ.delete(); riseQ.delete(); monOn = 1'b1;
    writeReg(REG_DATA, 8'($urandom));
    for (int k = 0; k < 400 && edgeCnt < 7; k++) @(negedge MHZ48);
    checkVal("abortEdge", edgeCnt, 7);
    #2 nRES = 1'b0;
    #1;
    checkVal("abortSclk", SCLK, 1'b0);
    checkVal("abortMosi", MOSI, 1'b1);
    checkVal("abortNss", nSS, 2'b11);
    checkVal("abortIrq", nIRQ, 1'b1);
    monOn = 1'b0;
    repeat (2) @(negedge MHZ48);
    nRES = 1'b1;
    readReg(REG_DATA, rd); checkVal("abortRx", rd, 8'h00);
    readReg(REG_CTRL, rd); checkVal("abortStatus", rd, 8'h00);
    readReg(REG_DIV, rd);  checkVal("abortDiv", rd, 8'd23);
    readReg(REG_SEL, rd);  checkVal("abortSel", rd, 8'h00);
    $display("abort at toggle %0d, registers back to reset values", edgeCnt);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
